// File: rtl/fix_requant_stream.sv
// fix_requant_stream: two-stage streaming fixed-point requantiser (shift/round, then sat/wrap).
// Define REQUANT_STATS_EN to build the sticky overflow flag and overflow beat counter.
module fix_requant_stream #(
    parameter int IN_W   = 32,
    parameter int IN_FW  = 16,
    parameter int OUT_W  = 16,
    parameter int OUT_FW = 12,
    parameter int CH     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          rnd_mode,
    input  logic                sat_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*IN_W-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*OUT_W-1:0] out_data,
    output logic                ovf_flag,
    output logic [15:0]         ovf_cnt,
    input  logic                clr_cnt
);

    localparam int SH = IN_FW - OUT_FW;
    localparam int RS = (SH > 0) ? SH : 1;
    localparam int LS = (SH < 0) ? -SH : 0;
    localparam int RW = (SH > 0) ? IN_W + 1 : IN_W + LS;

    localparam logic [RW-1:0] P_HALF = {{(RW-1){1'b0}}, 1'b1} << (RS - 1);
    localparam logic [RW-1:0] P_HALF_M1 = P_HALF - {{(RW-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] P_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] P_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                w_adv;
    logic [CH*RW-1:0]    w_r;
    logic [CH*OUT_W-1:0] w_q;
    logic [CH-1:0]       w_ovf;

    logic                r_s1_v;
    logic                r_s1_sat;
    logic [CH*RW-1:0]    r_s1_r;
    logic                r_s2_v;
    logic [CH*OUT_W-1:0] r_s2_q;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign w_adv     = !r_s2_v || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s2_v;
    assign out_data  = r_s2_q;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic [IN_W-1:0]  w_x;
        logic [RW-1:0]    w_s1;
        logic [RW-OUT_W:0] w_top;

        assign w_x = in_data[k*IN_W +: IN_W];

        if (SH > 0) begin : g_rsh
            logic signed [RW-1:0] w_xe;
            logic signed [RW-1:0] w_bias;
            logic signed [RW-1:0] w_sum;

            assign w_xe = {w_x[IN_W-1], w_x};

            always_comb begin
                w_bias = '0;
                case (rnd_mode)
                    2'd1:    w_bias = P_HALF;
                    2'd2:    w_bias = P_HALF_M1 + {{(RW-1){1'b0}}, w_x[RS]};
                    default: w_bias = '0;
                endcase
            end

            assign w_sum = w_xe + w_bias;
            assign w_r[k*RW +: RW] = w_sum >>> RS;
        end else if (SH == 0) begin : g_pass
            assign w_r[k*RW +: RW] = w_x;
        end else begin : g_lsh
            assign w_r[k*RW +: RW] = {{LS{w_x[IN_W-1]}}, w_x} << LS;
        end

        // In range iff every bit from the output sign bit upward agrees.
        assign w_s1     = r_s1_r[k*RW +: RW];
        assign w_top    = w_s1[RW-1:OUT_W-1];
        assign w_ovf[k] = !((&w_top) || !(|w_top));

        assign w_q[k*OUT_W +: OUT_W] = (w_ovf[k] && r_s1_sat)
                                     ? (w_s1[RW-1] ? P_MIN : P_MAX)
                                     : w_s1[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_sat <= 1'b0;
            r_s1_r   <= '0;
            r_s2_v   <= 1'b0;
            r_s2_q   <= '0;
        end else if (w_adv) begin
            r_s1_v <= in_valid;
            r_s2_v <= r_s1_v;
            if (in_valid) begin
                r_s1_sat <= sat_en;
                r_s1_r   <= w_r;
            end
            if (r_s1_v) begin
                r_s2_q <= w_q;
            end
        end
    end

`ifdef REQUANT_STATS_EN
    logic        r_s2_ovf;
    logic        r_flag;
    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_ovf <= 1'b0;
            r_flag   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_adv) begin
                r_s2_ovf <= r_s1_v && (|w_ovf);
            end
            // Clear beats a same-cycle increment.
            if (clr_cnt) begin
                r_flag <= 1'b0;
                r_cnt  <= '0;
            end else if (r_s2_v && out_ready && r_s2_ovf) begin
                r_flag <= 1'b1;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign ovf_flag = r_flag;
    assign ovf_cnt  = r_cnt;
`else
    logic w_unused;
    assign w_unused = clr_cnt;
    assign ovf_flag = 1'b0;
    assign ovf_cnt  = '0;
`endif

endmodule

// File: tb/tb_fix_requant_stream.sv
// tb_fix_requant_stream: randomized and directed bench for fix_requant_stream.
// Expected beats come from an arithmetic floor/round model, not from the RTL structure.
module tb_fix_requant_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rnd_mode;
    logic        sat_en;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ovf_flag;
    logic [15:0] ovf_cnt;
    logic        clr_cnt;

    int nvec = 0;
    int nfail = 0;

    logic [32:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_flag = 0;

    bit          s_acc, s_xf, s_ov, s_ird;
    logic [31:0] s_got, s_exp;

    always #5 clk = ~clk;

    fix_requant_stream dut (
        .clk(clk), .rst(rst), .rnd_mode(rnd_mode), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt), .clr_cnt(clr_cnt)
    );

    // Q16.16 -> Q4.12: divide by 16 with the chosen rounding, then range-limit.
    function automatic logic [16:0] ref_lane(input logic [31:0] x,
                                             input logic [1:0] rm, input bit se);
        longint v, q, rem;
        bit ovf;
        logic [15:0] o;
        v = longint'($signed(x));
        q = v / 16;
        if (v < 0 && (v % 16) != 0) q = q - 1;
        rem = v - q * 16;
        if (rm == 2'd1 && rem >= 8) q = q + 1;
        else if (rm == 2'd2 && (rem > 8 || (rem == 8 && (q % 2) != 0))) q = q + 1;
        ovf = (q > 32767) || (q < -32768);
        if (ovf && se) o = (q > 0) ? 16'h7FFF : 16'h8000;
        else o = q[15:0];
        return {ovf, o};
    endfunction

    function automatic logic [32:0] ref_beat(input logic [63:0] d,
                                             input logic [1:0] rm, input bit se);
        logic [16:0] a, b;
        a = ref_lane(d[31:0], rm, se);
        b = ref_lane(d[63:32], rm, se);
        return {a[16] | b[16], b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rnd_x();
        logic [31:0] t;
        t = $urandom();
        case ($urandom_range(2))
            0:       return {{12{t[19]}}, t[19:0]};
            1:       return {{14{t[17]}}, t[17:0]};
            default: return t;
        endcase
    endfunction

    // One clock: drive, observe at negedge, update model, return at posedge+1.
    task automatic step(input bit iv, input logic [63:0] d, input logic [1:0] rm,
                        input bit se, input bit ordy, input bit clr);
        logic [32:0] e;
        in_valid = iv; in_data = d; rnd_mode = rm;
        sat_en = se; out_ready = ordy; clr_cnt = clr;
        @(negedge clk);
        s_acc = in_valid && in_ready;
        s_ov  = out_valid;
        s_ird = in_ready;
        s_xf  = out_valid && out_ready;
        s_got = out_data;
        s_exp = 'x;
        e = '0;
        if (s_xf && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s_exp = e[31:0];
        end
        if (s_acc) exp_q.push_back(ref_beat(d, rm, se));
`ifdef REQUANT_STATS_EN
        if (clr) begin
            m_cnt = 0; m_flag = 0;
        end else if (s_xf && e[32]) begin
            m_flag = 1;
            if (m_cnt < 65535) m_cnt++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        nvec++; if (out_data !== 32'h0) begin nfail++; $display("FAIL rst_data: got %h want 0", out_data); end
        nvec++; if (ovf_flag !== 1'b0) begin nfail++; $display("FAIL rst_flag: got %0b want 0", ovf_flag); end
        nvec++; if (ovf_cnt !== 16'h0) begin nfail++; $display("FAIL rst_cnt: got %0d want 0", ovf_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        step(1, {32'hFFFF_0000, 32'h0001_8000}, 2'd0, 1'b1, 1'b1, 1'b0);
        nvec++; if (s_acc !== 1'b1) begin nfail++; $display("FAIL basic_acc: got %0b want 1", s_acc); end
        step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
        nvec++; if (s_xf !== 1'b0) begin nfail++; $display("FAIL basic_early: out_valid %0b want 0", s_xf); end
        step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
        nvec++;
        if (s_xf !== 1'b1 || s_got !== 32'hF000_1800 || s_got !== s_exp) begin
            nfail++; $display("FAIL basic_data: valid %0b got %h want f0001800", s_xf, s_got);
        end
        nvec++; if (ovf_cnt !== 16'(m_cnt)) begin nfail++; $display("FAIL basic_cnt: got %0d want %0d", ovf_cnt, m_cnt); end
    endtask

    task automatic test_rounding();
        logic [31:0] vals[3] = '{32'h18, 32'h28, 32'hFFFF_FFE8};
        int tab[9] = '{1, 2, -2, 2, 3, -1, 2, 2, -2};
        int n = 0;
        for (int c = 0; c < 20 && n < 9; c++) begin
            if (c < 9) step(1, {32'($urandom()), vals[c % 3]}, 2'(c / 3), 1'b1, 1'b1, 1'b0);
            else step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
            if (s_xf) begin
                nvec++;
                if (s_got !== s_exp || s_got[15:0] !== 16'(tab[n])) begin
                    nfail++;
                    $display("FAIL round_%0d: got %h want %h lane0 %0d", n, s_got, s_exp, tab[n]);
                end
                n++;
            end
        end
        nvec++; if (n != 9) begin nfail++; $display("FAIL round_count: got %0d want 9", n); end
    endtask

    task automatic test_overflow();
        logic [15:0] want[3] = '{16'h7FFF, 16'h0000, 16'h7FFF};
        step(0, '0, 2'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1, {32'h0, 32'h0010_0000}, 2'd0, k != 1, 1'b1, 1'b0);
            step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
            step(0, '0, 2'd0, 1'b1, 1'b1, k == 2);
            nvec++;
            if (s_xf !== 1'b1 || s_got !== s_exp || s_got[15:0] !== want[k]) begin
                nfail++; $display("FAIL ovf_data_%0d: got %h want %h", k, s_got, want[k]);
            end
            nvec++;
            if (ovf_cnt !== 16'(m_cnt) || ovf_flag !== m_flag) begin
                nfail++; $display("FAIL ovf_stats_%0d: cnt %0d flag %0b want %0d %0b", k, ovf_cnt, ovf_flag, m_cnt, m_flag);
            end
        end
`ifdef REQUANT_STATS_EN
        nvec++; if (ovf_cnt !== 16'h0) begin nfail++; $display("FAIL ovf_clr: cnt %0d want 0", ovf_cnt); end
`endif
    endtask

    task automatic test_stall();
        int nb = 0;
        int n = 0;
        bit pstall = 0;
        bit ordy;
        logic [31:0] pgot = '0;
        for (int c = 0; c < 80 && n < 20; c++) begin
            ordy = !(c >= 5 && c <= 9);
            step(nb < 20, {32'(-nb), 32'(nb << 12)}, 2'd1, 1'b1, ordy, 1'b0);
            if (s_acc) nb++;
            if (!ordy && s_ov) begin
                nvec++; if (s_ird !== 1'b0) begin nfail++; $display("FAIL stall_ready: got %0b want 0", s_ird); end
            end
            if (pstall) begin
                nvec++; if (s_got !== pgot) begin nfail++; $display("FAIL stall_hold: got %h want %h", s_got, pgot); end
            end
            if (s_xf) begin
                nvec++;
                if (s_got !== s_exp || s_got[15:0] !== 16'(n << 8)) begin
                    nfail++; $display("FAIL stall_beat_%0d: got %h want %h", n, s_got, s_exp);
                end
                n++;
            end
            pstall = s_ov && !ordy;
            pgot = s_got;
        end
        nvec++; if (n != 20) begin nfail++; $display("FAIL stall_count: got %0d want 20", n); end
    endtask

    task automatic test_random();
        int nin = 0;
        int nout = 0;
        for (int c = 0; c < 400 && (c < 300 || exp_q.size() > 0); c++) begin
            step(c < 300 && $urandom_range(3) != 0, {rnd_x(), rnd_x()},
                 2'($urandom_range(3)), 1'($urandom_range(1)),
                 c >= 300 || $urandom_range(3) != 0, $urandom_range(60) == 0);
            if (s_acc) nin++;
            if (s_xf) begin
                nout++;
                nvec++;
                if (s_got !== s_exp) begin nfail++; $display("FAIL rand_beat_%0d: got %h want %h", nout, s_got, s_exp); end
            end
        end
        nvec++; if (nout != nin) begin nfail++; $display("FAIL rand_count: got %0d want %0d", nout, nin); end
        nvec++;
        if (ovf_cnt !== 16'(m_cnt) || ovf_flag !== m_flag) begin
            nfail++; $display("FAIL rand_stats: cnt %0d flag %0b want %0d %0b", ovf_cnt, ovf_flag, m_cnt, m_flag);
        end
    endtask

    task automatic test_midreset();
        logic [63:0] d;
        step(1, {32'h0, 32'h8000_0000}, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1, 64'h0000_0100_0000_0200, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1, 64'h0000_0300_0000_0400, 2'd0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_cnt = 0; m_flag = 0;
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL mrst_valid: got %0b want 0", out_valid); end
        nvec++; if (ovf_cnt !== 16'h0 || out_data !== 32'h0) begin nfail++; $display("FAIL mrst_state: cnt %0d data %h want 0", ovf_cnt, out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        d = {rnd_x(), rnd_x()};
        step(1, d, 2'd2, 1'b1, 1'b1, 1'b0);
        step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
        nvec++; if (s_xf !== 1'b0) begin nfail++; $display("FAIL mrst_stale: out_valid %0b want 0", s_xf); end
        step(0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
        nvec++;
        if (s_xf !== 1'b1 || s_got !== s_exp) begin
            nfail++; $display("FAIL mrst_beat: valid %0b got %h want %h", s_xf, s_got, s_exp);
        end
    endtask

    initial begin
        rst = 1'b1; rnd_mode = '0; sat_en = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_stall();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, nfail=%0d", nfail);
        $fatal(1, "timeout");
    end

endmodule
